lane_logic_pipe: RTL and testbench

- Parametrised successor to the fixed 6-lane combinational OR/register cell.
- Applies a per-transaction bitwise operation across LANES independent bit lanes through a DEPTH-stage elastic pipeline with valid/ready handshakes on both sides.
- Keeps a sticky OR accumulator and a saturating completion counter.
- Used wherever flattened multi-lane combine cells are replicated in the netlist test designs.

---
 rtl/lane_logic_if.sv | 24 ++
 rtl/lane_logic_pipe.sv | 111 +++++++++++
 tb/tb_lane_logic_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_logic_if.sv
// Valid/ready bus for lane_logic_pipe: input transaction side and result side.
interface lane_logic_if #(
  parameter int unsigned LANES = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in1;
  logic [LANES-1:0] in2;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out1;
  logic [1:0]       out_op;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out1, out_op
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out1, out_op
  );
endinterface

// File: rtl/lane_logic_pipe.sv
// Per-lane AND/OR/XOR through a DEPTH-stage elastic pipeline, with a sticky
// OR accumulator and a saturating completion counter.
module lane_logic_pipe #(
  parameter int unsigned LANES = 6,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  lane_logic_if.slave      bus,
  input  logic             acc_clr,
  output logic [LANES-1:0] acc,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned LAST = DEPTH - 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  typedef struct packed {
    logic [LANES-1:0] res;
    logic [1:0]       op;
  } stage_t;

  logic [DEPTH-1:0] stg_vld;
  stage_t           stg_dat [DEPTH];
  logic [DEPTH-1:0] stg_ld;
  stage_t           in_dat;
  logic             xfer;
  logic             acc_upd;

  // Stage k can load unless it and every stage behind it are full and the output is stalled.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    stg_ld    = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      tail_full = tail_full & stg_vld[k];
      stg_ld[k] = bus.out_ready | ~tail_full;
    end
  end

  // Lane operation evaluated at acceptance.
  always_comb begin
    in_dat.op  = bus.op;
    in_dat.res = bus.in1 | bus.in2;
    case (bus.op)
      OP_AND:  in_dat.res = bus.in1 & bus.in2;
      OP_OR:   in_dat.res = bus.in1 | bus.in2;
      OP_XOR:  in_dat.res = bus.in1 ^ bus.in2;
      OP_ACC:  in_dat.res = bus.in1 | bus.in2;
      default: in_dat.res = bus.in1 | bus.in2;
    endcase
  end

  assign bus.in_ready  = stg_ld[0];
  assign bus.out_valid = stg_vld[LAST];
  assign bus.out1      = stg_dat[LAST].res;
  assign bus.out_op    = stg_dat[LAST].op;

  assign xfer    = stg_vld[LAST] & bus.out_ready;
  assign acc_upd = xfer & (stg_dat[LAST].op == OP_ACC);

  // Pipeline stages; data only moves when a valid entry is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        stg_dat[k] <= '0;
      end
    end else begin
      if (stg_ld[0]) begin
        stg_vld[0] <= bus.in_valid;
        if (bus.in_valid) begin
          stg_dat[0] <= in_dat;
        end
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (stg_ld[k]) begin
          stg_vld[k] <= stg_vld[k-1];
          if (stg_vld[k-1]) begin
            stg_dat[k] <= stg_dat[k-1];
          end
        end
      end
    end
  end

  // Clear is applied before the same-cycle accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= acc_upd ? stg_dat[LAST].res : '0;
    end else if (acc_upd) begin
      acc <= acc | stg_dat[LAST].res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (xfer && !(&done_cnt)) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lane_logic_pipe.sv
// Bench for lane_logic_pipe: directed scenarios plus random traffic against a
// queue-based transaction model, on three parameter sets.
module tb_lane_logic_pipe;

  localparam int unsigned LA = 6;
  localparam int unsigned DA = 2;
  localparam int unsigned LC = 1;
  localparam int unsigned DC = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_logic_if #(.LANES(LA)) ifa ();
  lane_logic_if #(.LANES(LA)) ifb ();
  lane_logic_if #(.LANES(LC)) ifc ();

  logic          clr_a, clr_c;
  logic [LA-1:0] acc_a, acc_b;
  logic [LC-1:0] acc_c;
  logic [15:0]   cnt_a, cnt_c;
  logic [2:0]    cnt_b;

  lane_logic_pipe #(.LANES(LA), .DEPTH(DA), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .acc_clr(clr_a), .acc(acc_a), .done_cnt(cnt_a));
  lane_logic_pipe #(.LANES(LA), .DEPTH(DA), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .acc_clr(clr_a), .acc(acc_b), .done_cnt(cnt_b));
  lane_logic_pipe #(.LANES(LC), .DEPTH(DC), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc), .acc_clr(clr_c), .acc(acc_c), .done_cnt(cnt_c));

  // dut_b mirrors dut_a's traffic; only its counter width differs
  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in1       = ifa.in1;
  assign ifb.in2       = ifa.in2;
  assign ifb.op        = ifa.op;
  assign ifb.out_ready = ifa.out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [1:0]  op;
    int          t;
  } item_t;

  item_t       qa[$];
  item_t       qc[$];
  int          cyc = 0;
  logic [31:0] macc_a, macc_c;
  int          mcnt_a, mcnt_b, mcnt_c;
  bit          armed_a = 1'b0, armed_c = 1'b0;
  bit          post_rst_a = 1'b0, post_rst_c = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model A/B: head of queue is visible DEPTH cycles after its acceptance cycle.
  always @(negedge clk) begin
    logic ev, er, xf;
    item_t it;
    ev = 1'b0;
    if (qa.size() > 0) ev = (cyc >= qa[0].t + int'(DA));
    er = (qa.size() < int'(DA)) || ifa.out_ready;
    if (armed_a) begin
      check("a_out_valid", 32'(ifa.out_valid), 32'(ev));
      if (ev) begin
        check("a_out1", 32'(ifa.out1), qa[0].res);
        check("a_out_op", 32'(ifa.out_op), 32'(qa[0].op));
        check("b_out1", 32'(ifb.out1), qa[0].res);
      end else if (post_rst_a) begin
        check("a_out1_rst", 32'(ifa.out1), 32'd0);
        check("a_out_op_rst", 32'(ifa.out_op), 32'd0);
      end
      check("a_in_ready", 32'(ifa.in_ready), 32'(er));
      check("a_acc", 32'(acc_a), macc_a);
      check("a_done_cnt", 32'(cnt_a), 32'(mcnt_a));
      check("b_done_cnt", 32'(cnt_b), 32'(mcnt_b));
    end
    post_rst_a = 1'b0;
    if (rst) begin
      qa.delete();
      macc_a = 0; mcnt_a = 0; mcnt_b = 0;
      armed_a = 1'b1; post_rst_a = 1'b1;
    end else begin
      xf = ev && ifa.out_ready;
      if (clr_a) macc_a = 0;
      if (xf) begin
        it = qa.pop_front();
        if (it.op == 2'b11) macc_a = macc_a | it.res;
        if (mcnt_a < 65535) mcnt_a++;
        if (mcnt_b < 7) mcnt_b++;
      end
      if (ifa.in_valid && er)
        qa.push_back('{res: ref_op(ifa.op, 32'(ifa.in1), 32'(ifa.in2)), op: ifa.op, t: cyc});
    end
  end

  always @(negedge clk) begin
    logic ev, er, xf;
    item_t it;
    ev = 1'b0;
    if (qc.size() > 0) ev = (cyc >= qc[0].t + int'(DC));
    er = (qc.size() < int'(DC)) || ifc.out_ready;
    if (armed_c) begin
      check("c_out_valid", 32'(ifc.out_valid), 32'(ev));
      if (ev) begin
        check("c_out1", 32'(ifc.out1), qc[0].res);
        check("c_out_op", 32'(ifc.out_op), 32'(qc[0].op));
      end else if (post_rst_c) begin
        check("c_out1_rst", 32'(ifc.out1), 32'd0);
      end
      check("c_in_ready", 32'(ifc.in_ready), 32'(er));
      check("c_acc", 32'(acc_c), macc_c);
      check("c_done_cnt", 32'(cnt_c), 32'(mcnt_c));
    end
    post_rst_c = 1'b0;
    if (rst) begin
      qc.delete();
      macc_c = 0; mcnt_c = 0;
      armed_c = 1'b1; post_rst_c = 1'b1;
    end else begin
      xf = ev && ifc.out_ready;
      if (clr_c) macc_c = 0;
      if (xf) begin
        it = qc.pop_front();
        if (it.op == 2'b11) macc_c = macc_c | it.res;
        if (mcnt_c < 65535) mcnt_c++;
      end
      if (ifc.in_valid && er)
        qc.push_back('{res: ref_op(ifc.op, 32'(ifc.in1), 32'(ifc.in2)), op: ifc.op, t: cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [LA-1:0] a, input logic [LA-1:0] b, input logic [1:0] op);
    ifa.in_valid = v;
    ifa.in1      = a;
    ifa.in2      = b;
    ifa.op       = op;
  endtask

  initial begin
    rst = 1'b1;
    clr_a = 1'b0; clr_c = 1'b0;
    drive_a(1'b0, '0, '0, 2'b00);
    ifa.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in1 = '0; ifc.in2 = '0; ifc.op = 2'b00; ifc.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_done_cnt", 32'(cnt_a), 32'd0);

    // three ops back to back, 2-cycle latency
    drive_a(1'b1, 6'b101100, 6'b100110, 2'b00); tick();
    drive_a(1'b1, 6'b101100, 6'b100110, 2'b01); tick();
    check("seq_and", 32'(ifa.out1), 32'b100100);
    drive_a(1'b1, 6'b101100, 6'b100110, 2'b10); tick();
    check("seq_or", 32'(ifa.out1), 32'b101110);
    ifa.in_valid = 1'b0; tick();
    check("seq_xor", 32'(ifa.out1), 32'b001010);
    tick();
    check("seq_cnt", 32'(cnt_a), 32'd3);
    check("seq_drained", 32'(ifa.out_valid), 32'd0);

    // backpressure: two fit, third stalls until out_ready rises
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 6'b111000, 6'b101010, 2'b01); #1;
    check("bp_rdy1", 32'(ifa.in_ready), 32'd1); tick();
    drive_a(1'b1, 6'b110011, 6'b010110, 2'b10); #1;
    check("bp_rdy2", 32'(ifa.in_ready), 32'd1); tick();
    drive_a(1'b1, 6'b011110, 6'b001111, 2'b00); #1;
    check("bp_full", 32'(ifa.in_ready), 32'd0);
    check("bp_hold0", 32'(ifa.out1), 32'b111010);
    tick();
    check("bp_full2", 32'(ifa.in_ready), 32'd0);
    check("bp_hold1", 32'(ifa.out1), 32'b111010);
    ifa.out_ready = 1'b1; #1;
    check("bp_release_rdy", 32'(ifa.in_ready), 32'd1);
    tick();
    ifa.in_valid = 1'b0;
    check("bp_x2", 32'(ifa.out1), 32'b100101);
    tick();
    check("bp_x3", 32'(ifa.out1), 32'b001110);
    tick();
    check("bp_no_dup", 32'(ifa.out_valid), 32'd0);
    check("bp_cnt", 32'(cnt_a), 32'd6);

    // accumulator
    drive_a(1'b1, 6'b000001, 6'b000010, 2'b11); tick();
    ifa.in_valid = 1'b0; tick(); tick();
    check("acc_1", 32'(acc_a), 32'b000011);
    drive_a(1'b1, 6'b010000, 6'b000000, 2'b11); tick();
    ifa.in_valid = 1'b0; tick(); tick();
    check("acc_2", 32'(acc_a), 32'b010011);
    drive_a(1'b1, 6'b100000, 6'b000000, 2'b11); tick();
    ifa.in_valid = 1'b0; tick();
    check("acc_clr_xfer_vld", 32'(ifa.out_valid), 32'd1);
    clr_a = 1'b1; tick();
    clr_a = 1'b0;
    check("acc_clr_xfer", 32'(acc_a), 32'b100000);
    clr_a = 1'b1; tick();
    clr_a = 1'b0;
    check("acc_clr_only", 32'(acc_a), 32'd0);
    check("acc_cnt", 32'(cnt_a), 32'd9);
    check("sat_b", 32'(cnt_b), 32'd7);

    // reset with work in flight
    drive_a(1'b1, 6'b001100, 6'b000001, 2'b11); tick();
    ifa.in_valid = 1'b0; tick(); tick();
    check("acc_pre_rst", 32'(acc_a), 32'b001101);
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 6'b111111, 6'b000111, 2'b10); tick();
    drive_a(1'b1, 6'b010101, 6'b101010, 2'b01); tick();
    ifa.in_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("mid_rst_acc", 32'(acc_a), 32'd0);
    check("mid_rst_cnt", 32'(cnt_a), 32'd0);
    check("mid_rst_in_ready", 32'(ifa.in_ready), 32'd1);
    ifa.out_ready = 1'b1;
    tick(); tick(); tick();
    check("mid_rst_flushed", 32'(ifa.out_valid), 32'd0);

    // dut_c: streaming XOR at full rate, 1-cycle latency
    for (int i = 0; i < 40; i++) begin
      ifc.in_valid = 1'b1;
      ifc.op       = 2'b10;
      ifc.in1      = 1'($urandom);
      ifc.in2      = 1'($urandom);
      tick();
    end
    ifc.in_valid = 1'b0;
    tick();
    check("c_stream_cnt", 32'(cnt_c), 32'd40);

    // random traffic on all instances
    for (int i = 0; i < 800; i++) begin
      drive_a(($urandom % 4) != 0, LA'($urandom), LA'($urandom), 2'($urandom));
      ifa.out_ready = ($urandom % 3) != 0;
      clr_a         = ($urandom % 16) == 0;
      ifc.in_valid  = ($urandom % 4) != 0;
      ifc.in1       = LC'($urandom);
      ifc.in2       = LC'($urandom);
      ifc.op        = 2'($urandom);
      ifc.out_ready = ($urandom % 3) != 0;
      clr_c         = ($urandom % 16) == 0;
      rst           = (i == 400);
      tick();
    end
    rst = 1'b0;
    clr_a = 1'b0; clr_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    repeat (5) tick();
    check("end_drained_a", 32'(ifa.out_valid), 32'd0);
    check("end_sat_b", 32'(cnt_b), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
